hazard_ctrl: RTL and testbench

//  Sequences the 5-stage RISC-V pipeline registers (Fetch/Decode/Execute/Memory/Writeback).

---
 rtl/hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage RISC-V core: stall/flush sequencing,
// EX-stage forwarding selects, data-memory wait FSM with timeout, event counters.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             Error,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } state_t;

  state_t            state_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_nxt_s;
  logic              error_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;
  logic              lu_s;
  logic              mw_s;
  logic              hold_s;
  logic              run_s;

  // Memory stage wins over Writeback; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic       wr_m,
    input logic [4:0] rd_m,
    input logic       wr_w,
    input logic [4:0] rd_w
  );
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // Hazard detection and same-cycle stall/flush/forward decode.
  always_comb begin
    lu_s       = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    mw_s       = MemReqM && !MemReadyM;
    wait_nxt_s = wait_cnt_r + WAIT_W'(1);
    hold_s     = 1'b0;
    run_s      = 1'b0;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushW     = 1'b0;
    ForwardAE  = 2'b00;
    ForwardBE  = 2'b00;

    case (state_r)
      RUN: begin
        run_s = 1'b1;
      end
      MEM_WAIT: begin
        if (MemReadyM) begin
          run_s = 1'b1;
        end else begin
          hold_s = 1'b1;
        end
      end
      ERROR: begin
        hold_s = 1'b1;
      end
      default: begin
        hold_s = 1'b1;
      end
    endcase

    if (!reset) begin
      StallF = 1'b0;
    end else if (hold_s || (run_s && mw_s)) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (run_s && PCSrcE) begin
      // The Decode instruction is discarded, so a concurrent load-use is moot.
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (run_s && lu_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = 1'b0;
    end

    if (reset) begin
      ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
      ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    end else begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end
  end

  // Wait-state FSM, sticky timeout error and saturating event counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= RUN;
      wait_cnt_r  <= '0;
      error_r     <= 1'b0;
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (StallF && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (FlushE && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end

      case (state_r)
        RUN: begin
          if (mw_s) begin
            state_r    <= MEM_WAIT;
            wait_cnt_r <= '0;
          end
        end
        MEM_WAIT: begin
          if (MemReadyM) begin
            state_r <= RUN;
          end else if (wait_nxt_s == WAIT_W'(MEM_TIMEOUT)) begin
            state_r <= ERROR;
            error_r <= 1'b1;
          end else begin
            wait_cnt_r <= wait_nxt_s;
          end
        end
        ERROR: begin
          error_r <= 1'b1;
        end
        default: begin
          state_r <= ERROR;
          error_r <= 1'b1;
        end
      endcase
    end
  end

  assign Error      = error_r;
  assign StallCount = stall_cnt_r;
  assign FlushCount = flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=3): a behavioural model
// queues expected controls per driven cycle, compared at the following negedge.
module tb_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          Error;
  logic [CW-1:0] StallCount, FlushCount;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE),
    .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .Error(Error),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       regwm, regww, load, pcsrc, memreq, memrdy;
  } vec_t;

  typedef struct packed {
    logic [3:0]    stall;   // F D E M
    logic [2:0]    flush;   // D E W
    logic [1:0]    fa, fb;
    logic          err;
    logic [CW-1:0] sc, fc;
  } exp_t;

  exp_t          q[$];
  int            total = 0;
  int            bad   = 0;
  int            m_state;
  int            m_wait;
  logic          m_err;
  logic [CW-1:0] m_sc, m_fc;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
    RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
    RegWriteM = v.regwm; RegWriteW = v.regww; LoadE = v.load;
    PCSrcE = v.pcsrc; MemReqM = v.memreq; MemReadyM = v.memrdy;
  endtask

  function automatic logic [1:0] exp_fwd(input vec_t v, input logic [4:0] rs);
    logic [1:0] f;
    f = 2'b00;
    if (v.regww && v.rdw != 5'd0 && v.rdw == rs) f = 2'b01;
    if (v.regwm && v.rdm != 5'd0 && v.rdm == rs) f = 2'b10;
    return f;
  endfunction

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_err = 1'b0; m_sc = '0; m_fc = '0;
    q.delete();
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    exp_t x;
    logic lu, mw, freeze;
    @(posedge clock); #1;
    drive(v);
    lu     = v.load && v.rde != 5'd0 && (v.rde == v.rs1d || v.rde == v.rs2d);
    mw     = v.memreq && !v.memrdy;
    freeze = (m_state == 2) || (m_state == 1 && !v.memrdy) || (m_state == 0 && mw);
    e = '0;
    if (freeze) begin
      e.stall = 4'b1111; e.flush = 3'b001;
    end else if (v.pcsrc) begin
      e.flush = 3'b110;
    end else if (lu) begin
      e.stall = 4'b1100; e.flush = 3'b010;
    end
    e.fa = exp_fwd(v, v.rs1e);
    e.fb = exp_fwd(v, v.rs2e);
    e.err = m_err; e.sc = m_sc; e.fc = m_fc;
    q.push_back(e);

    @(negedge clock);
    x = q.pop_front();
    check("stall", 8'({StallF, StallD, StallE, StallM}), 8'(x.stall));
    check("flush", 8'({FlushD, FlushE, FlushW}), 8'(x.flush));
    check("fwd_a", 8'(ForwardAE), 8'(x.fa));
    check("fwd_b", 8'(ForwardBE), 8'(x.fb));
    check("error", 8'(Error), 8'(x.err));
    check("stall_cnt", 8'(StallCount), 8'(x.sc));
    check("flush_cnt", 8'(FlushCount), 8'(x.fc));

    // Advance the model across the coming clock edge.
    if (x.stall[3] && m_sc != {CW{1'b1}}) m_sc = m_sc + CW'(1);
    if (x.flush[1] && m_fc != {CW{1'b1}}) m_fc = m_fc + CW'(1);
    case (m_state)
      0: if (mw) begin m_state = 1; m_wait = 0; end
      1: begin
        if (v.memrdy) m_state = 0;
        else begin
          m_wait++;
          if (m_wait == TO) begin m_state = 2; m_err = 1'b1; end
        end
      end
      default: m_state = 2;
    endcase
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_stall"}, 8'({StallF, StallD, StallE, StallM}), 8'h00);
    check({tag, "_flush"}, 8'({FlushD, FlushE, FlushW}), 8'h00);
    check({tag, "_fwd"}, 8'({ForwardAE, ForwardBE}), 8'h00);
    check({tag, "_err"}, 8'(Error), 8'h00);
    check({tag, "_cnt"}, 8'({StallCount, FlushCount}), 8'h00);
  endtask

  task automatic do_reset();
    vec_t z;
    z = '0;
    drive(z);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  initial begin
    vec_t v;
    vec_t z;
    z = '0;
    reset = 1'b1;
    drive(z);
    model_reset();
    #2 reset = 1'b0;
    // Hostile inputs while in reset: every control must stay low.
    v = '0; v.memreq = 1'b1; v.pcsrc = 1'b1; v.regwm = 1'b1; v.rdm = 5'd3; v.rs1e = 5'd3;
    drive(v);
    #1 check_quiet("in_reset");
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_quiet("in_reset_clk");
    drive(z);
    reset = 1'b1;

    // Forwarding.
    v = '0; v.regwm = 1'b1; v.rdm = 5'd5; v.rs1e = 5'd5; apply(v);
    v = '0; v.regww = 1'b1; v.rdw = 5'd5; v.rs1e = 5'd5; apply(v);
    v = '0; v.regwm = 1'b1; v.rdm = 5'd0; v.rs1e = 5'd0; apply(v);
    v = '0; v.regwm = 1'b1; v.rdm = 5'd9; v.regww = 1'b1; v.rdw = 5'd9; v.rs2e = 5'd9; apply(v);
    v = '0; v.regwm = 1'b0; v.rdm = 5'd4; v.regww = 1'b1; v.rdw = 5'd4; v.rs2e = 5'd4; v.rs1e = 5'd4; apply(v);

    // Single load-use bubble.
    do_reset();
    v = '0; v.load = 1'b1; v.rde = 5'd7; v.rs2d = 5'd7; apply(v);
    apply(z);
    check("lu_stall_count", 8'(StallCount), 8'd1);
    check("lu_flush_count", 8'(FlushCount), 8'd1);
    v = '0; v.load = 1'b1; v.rde = 5'd0; v.rs1d = 5'd0; apply(v);

    // Taken branch overrides load-use.
    v = '0; v.load = 1'b1; v.rde = 5'd7; v.rs1d = 5'd7; v.pcsrc = 1'b1; apply(v);

    // Three wait cycles, release, then RUN behaviour resumes.
    do_reset();
    v = '0; v.memreq = 1'b1;
    repeat (3) apply(v);
    v.memrdy = 1'b1; apply(v);
    v = '0; v.load = 1'b1; v.rde = 5'd2; v.rs1d = 5'd2; apply(v);
    // Branch held through a wait flushes on the release cycle.
    v = '0; v.memreq = 1'b1; v.pcsrc = 1'b1;
    repeat (2) apply(v);
    v.memrdy = 1'b1; apply(v);
    apply(z);

    // Timeout into ERROR.
    do_reset();
    v = '0; v.memreq = 1'b1;
    repeat (5) apply(v);
    check("err_before_timeout", 8'(Error), 8'd0);
    apply(v);
    check("err_after_timeout", 8'(Error), 8'd1);
    v.memrdy = 1'b1; apply(v);
    apply(z);
    check("err_sticky", 8'(Error), 8'd1);
    do_reset();
    check("err_cleared", 8'(Error), 8'd0);

    // Counter saturation.
    v = '0; v.load = 1'b1; v.rde = 5'd11; v.rs1d = 5'd11;
    repeat (9) apply(v);
    apply(z);
    check("stall_cnt_sat", 8'(StallCount), 8'd7);
    check("flush_cnt_sat", 8'(FlushCount), 8'd7);

    // Reset in the middle of a memory wait.
    do_reset();
    v = '0; v.memreq = 1'b1;
    repeat (2) apply(v);
    #2 reset = 1'b0;
    #1 check_quiet("mid_wait_reset");
    @(negedge clock);
    drive(z);
    reset = 1'b1;
    model_reset();
    apply(z);

    // Randomised mix against the model.
    for (int i = 0; i < 80; i++) begin
      v.rs1d = 5'($urandom_range(0, 3)); v.rs2d = 5'($urandom_range(0, 3));
      v.rs1e = 5'($urandom_range(0, 3)); v.rs2e = 5'($urandom_range(0, 3));
      v.rde  = 5'($urandom_range(0, 3)); v.rdm  = 5'($urandom_range(0, 3));
      v.rdw  = 5'($urandom_range(0, 3));
      v.regwm  = 1'($urandom_range(0, 1)); v.regww = 1'($urandom_range(0, 1));
      v.load   = 1'($urandom_range(0, 1));
      v.pcsrc  = ($urandom_range(0, 3) == 0);
      v.memreq = ($urandom_range(0, 2) == 0);
      v.memrdy = ($urandom_range(0, 2) != 0);
      apply(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
